spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_sync.sv | 37 +++
 rtl/spi_slave.sv | 195 +++++++++++++++++++
 tb/tb_spi_slave.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared constants and FSM encoding for the SPI slave and its master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_slave_pkg;

  // Default ID bytes that open a write or a read frame.
  localparam logic [7:0] SLAVE_IDW_DEFAULT = 8'hFF;
  localparam logic [7:0] SLAVE_IDR_DEFAULT = 8'h00;

  // One frame is ID byte + address byte + data byte.
  localparam int FRAME_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ID   = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_SKIP = 3'd4
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer plus edge detector for one asynchronous SPI pin.
// Latency: level 2 clocks after the pin; rise/fall pulse valid in the same cycle as the new level.
// Backpressure: none. Ports: clock_i, reset_i (sync, active-high), pin_i -> level_o, rise_o, fall_o.
module spi_sync
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with a small 8-bit register file (24-bit ID/addr/data frames).
// Latency: pin edge acted on 3 clocks later; wr_strobe/rd_strobe 1 clock after the 24th rise event.
// Backpressure: none; master paces the link. Ports: clock, reset, sclk/ss/mosi/miso, host_addr/host_rdata,
//   wr_strobe/wr_addr/wr_data, rd_strobe, frame_err.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic [7:0] SLAVE_IDW = SLAVE_IDW_DEFAULT,
  parameter logic [7:0] SLAVE_IDR = SLAVE_IDR_DEFAULT,
  parameter int         REG_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_strobe,
  output logic       frame_err
);

  localparam int         IW     = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [8:0] DEPTH9 = 9'(REG_DEPTH);

  // Range check uses the full 8-bit address; indexing uses only the low IW bits.
  function automatic logic in_range(input logic [7:0] a);
    return ({1'b0, a} < DEPTH9);
  endfunction

  logic sclk_rise, sclk_fall, ss_lvl, ss_fall, mosi_lvl;
  logic sclk_lvl_unused, ss_rise_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clock_i(clock), .reset_i(reset), .pin_i(sclk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clock_i(clock), .reset_i(reset), .pin_i(ss),
    .level_o(ss_lvl), .rise_o(ss_rise_unused), .fall_o(ss_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clock_i(clock), .reset_i(reset), .pin_i(mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic       rw_q;
  logic       done_q;
  logic [1:0] settle_q;
  logic       armed_q;
  logic [6:0] shift_q;
  logic [7:0] shift_d;
  logic [6:0] tx_q;
  logic [7:0] rd_byte;
  logic [7:0] addr_q;
  logic       miso_q, wr_strobe_q, rd_strobe_q, frame_err_q;
  logic [7:0] wr_addr_q, wr_data_q, host_rdata_q;
  logic [7:0] regs_q [REG_DEPTH];

  // Byte as it will stand once the current mosi sample is shifted in.
  assign shift_d = {shift_q, mosi_lvl};
  // Read data for the address byte completing right now.
  assign rd_byte = in_range(shift_d) ? regs_q[shift_d[IW-1:0]] : 8'h00;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rw_q         <= 1'b0;
      done_q       <= 1'b0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
      shift_q      <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      miso_q       <= 1'b0;
      wr_strobe_q  <= 1'b0;
      rd_strobe_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      host_rdata_q <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;

      // The ss synchronizer resets to 1, so its first few cycles are not the pin.
      // Only a real ss-high observation afterwards arms frame detection, which
      // keeps a frame interrupted by reset from being picked up halfway.
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      else if (ss_lvl)      armed_q  <= 1'b1;

      host_rdata_q <= in_range(host_addr) ? regs_q[host_addr[IW-1:0]] : 8'h00;

      if (state_q != ST_IDLE && ss_lvl) begin
        if (state_q == ST_ID || state_q == ST_ADDR || (state_q == ST_DATA && !done_q))
          frame_err_q <= 1'b1;
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        done_q    <= 1'b0;
        miso_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (armed_q && ss_fall) begin
              state_q   <= ST_ID;
              bit_cnt_q <= '0;
              done_q    <= 1'b0;
              rw_q      <= 1'b0;
            end
          end
          ST_ID: begin
            if (sclk_rise) begin
              shift_q   <= shift_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= '0;
                if (shift_d == SLAVE_IDW) begin
                  rw_q    <= 1'b1;
                  state_q <= ST_ADDR;
                end else if (shift_d == SLAVE_IDR) begin
                  rw_q    <= 1'b0;
                  state_q <= ST_ADDR;
                end else begin
                  state_q     <= ST_SKIP;
                  frame_err_q <= 1'b1;
                end
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise) begin
              shift_q   <= shift_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= '0;
                addr_q    <= shift_d;
                state_q   <= ST_DATA;
                // Bit 7 must already be on miso before the master's first data rise.
                if (!rw_q) begin
                  tx_q   <= rd_byte[6:0];
                  miso_q <= rd_byte[7];
                end
              end
            end
          end
          ST_DATA: begin
            if (!done_q) begin
              if (sclk_rise) begin
                shift_q   <= shift_d[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  done_q <= 1'b1;
                  if (rw_q) begin
                    if (in_range(addr_q)) regs_q[addr_q[IW-1:0]] <= shift_d;
                    wr_strobe_q <= 1'b1;
                    wr_addr_q   <= addr_q;
                    wr_data_q   <= shift_d;
                  end else begin
                    rd_strobe_q <= 1'b1;
                  end
                end
              end else if (sclk_fall && !rw_q && bit_cnt_q != 3'd0) begin
                // The fall right after the address byte is skipped: bit 7 is
                // still being presented for the first data rise.
                tx_q   <= {tx_q[5:0], 1'b0};
                miso_q <= tx_q[6];
              end
            end
          end
          ST_SKIP: begin
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign miso       = miso_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_strobe  = rd_strobe_q;
  assign frame_err  = frame_err_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave; bench-side SPI master with a 4-clock half period.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave;
  import spi_slave_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sclk  = 1'b0;
  logic       ss    = 1'b1;
  logic       mosi  = 1'b0;
  logic [7:0] host_addr = 8'h00;
  logic       miso;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_strobe;
  logic       frame_err;

  int tests = 0;
  int fails = 0;

  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, miso_hi = 0;
  logic [7:0] last_wa = 8'h00, last_wd = 8'h00;
  int w0, r0, e0, m0;

  always #5 clock = ~clock;

  spi_slave dut (
    .clock(clock), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .host_addr(host_addr), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .frame_err(frame_err)
  );

  // Event monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (wr_strobe) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (rd_strobe) rd_cnt++;
    if (frame_err) err_cnt++;
    if (miso)      miso_hi++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    w0 = wr_cnt;
    r0 = rd_cnt;
    e0 = err_cnt;
    m0 = miso_hi;
  endtask

  task automatic host_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    host_addr = a;
    wait_clk(1);
    chk(tag, host_rdata, exp);
  endtask

  // Mode-0 master: mosi set while sclk low, miso sampled at the rising edge.
  task automatic spi_xfer(input logic [7:0] id, input logic [7:0] addr, input logic [7:0] data,
                          input int nbits, input bit end_frame, output logic [7:0] rx);
    logic [23:0] word;
    word = {id, addr, data};
    rx   = 8'h00;
    ss   = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < FRAME_BITS) ? word[23-i] : 1'b0;
      wait_clk(4);
      sclk = 1'b1;
      if (i >= 16 && i < FRAME_BITS) rx = {rx[6:0], miso};
      wait_clk(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    if (end_frame) begin
      wait_clk(6);
      ss = 1'b1;
      wait_clk(8);
    end
  endtask

  initial begin
    logic [7:0] rx;

    // Reset state
    reset = 1'b1;
    wait_clk(3);
    chk("rst_miso",       miso,       0);
    chk("rst_wr_strobe",  wr_strobe,  0);
    chk("rst_rd_strobe",  rd_strobe,  0);
    chk("rst_frame_err",  frame_err,  0);
    chk("rst_wr_addr",    wr_addr,    0);
    chk("rst_wr_data",    wr_data,    0);
    chk("rst_host_rdata", host_rdata, 0);
    reset = 1'b0;
    wait_clk(8);

    // Write 0x05 <= 0xA5
    snap();
    spi_xfer(8'hFF, 8'h05, 8'hA5, 24, 1'b1, rx);
    chk("wr05_strobes",  wr_cnt - w0, 1);
    chk("wr05_addr",     last_wa, 8'h05);
    chk("wr05_data",     last_wd, 8'hA5);
    chk("wr05_no_rd",    rd_cnt - r0, 0);
    chk("wr05_no_err",   err_cnt - e0, 0);
    chk("wr05_miso_low", miso_hi - m0, 0);
    host_chk("wr05_host", 8'h05, 8'hA5);

    // Read 0x05 back; mosi data byte is ignored
    snap();
    spi_xfer(8'h00, 8'h05, 8'h3C, 24, 1'b1, rx);
    chk("rd05_rdata",   rx, 8'hA5);
    chk("rd05_strobes", rd_cnt - r0, 1);
    chk("rd05_no_wr",   wr_cnt - w0, 0);
    chk("rd05_no_err",  err_cnt - e0, 0);

    // Unknown ID 0x3C
    snap();
    spi_xfer(8'h3C, 8'h05, 8'h5A, 24, 1'b1, rx);
    chk("badid_err",    err_cnt - e0, 1);
    chk("badid_no_wr",  wr_cnt - w0, 0);
    chk("badid_no_rd",  rd_cnt - r0, 0);
    chk("badid_miso",   miso_hi - m0, 0);
    host_chk("badid_reg05", 8'h05, 8'hA5);

    // Out-of-range write 0x20 <= 0x77 (index would alias to reg 0)
    snap();
    spi_xfer(8'hFF, 8'h20, 8'h77, 24, 1'b1, rx);
    chk("oor_wr_strobe", wr_cnt - w0, 1);
    chk("oor_wr_addr",   last_wa, 8'h20);
    chk("oor_wr_data",   last_wd, 8'h77);
    host_chk("oor_reg00",  8'h00, 8'h00);
    host_chk("oor_host20", 8'h20, 8'h00);
    host_chk("oor_reg05",  8'h05, 8'hA5);
    snap();
    spi_xfer(8'h00, 8'h20, 8'hFF, 24, 1'b1, rx);
    chk("oor_rd_rdata",  rx, 8'h00);
    chk("oor_rd_strobe", rd_cnt - r0, 1);

    // Write to 0x03 aborted after 20 bits, then a complete retry
    snap();
    spi_xfer(8'hFF, 8'h03, 8'hC3, 20, 1'b1, rx);
    chk("abort_err",   err_cnt - e0, 1);
    chk("abort_no_wr", wr_cnt - w0, 0);
    host_chk("abort_reg03", 8'h03, 8'h00);
    snap();
    spi_xfer(8'hFF, 8'h03, 8'h5A, 24, 1'b1, rx);
    chk("retry_wr",     wr_cnt - w0, 1);
    chk("retry_no_err", err_cnt - e0, 0);
    host_chk("retry_reg03", 8'h03, 8'h5A);

    // Extra clocks past bit 24 are ignored
    snap();
    spi_xfer(8'hFF, 8'h07, 8'hC3, 28, 1'b1, rx);
    chk("extra_wr",     wr_cnt - w0, 1);
    chk("extra_no_err", err_cnt - e0, 0);
    host_chk("extra_reg07", 8'h07, 8'hC3);

    // Reset in the DATA phase of a read of 0x05 (0xA5): after 18 bits miso holds bit 5 = 1
    snap();
    spi_xfer(8'h00, 8'h05, 8'h00, 18, 1'b0, rx);
    wait_clk(4);
    chk("midrst_pre_miso", miso, 1);
    reset = 1'b1;
    wait_clk(1);
    chk("midrst_miso", miso, 0);
    reset = 1'b0;
    host_chk("midrst_reg05", 8'h05, 8'h00);
    ss = 1'b1;
    wait_clk(8);
    chk("midrst_no_err", err_cnt - e0, 0);
    chk("midrst_no_rd",  rd_cnt - r0, 0);

    // A fresh frame after reset works
    snap();
    spi_xfer(8'hFF, 8'h01, 8'h42, 24, 1'b1, rx);
    chk("post_rst_wr", wr_cnt - w0, 1);
    host_chk("post_rst_reg01", 8'h01, 8'h42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
